// File: rtl/matrix_route_ctrl_pkg.sv
// Shared definitions for the audio routing matrix and its route controller.
package matrix_route_ctrl_pkg;

  localparam int SEL_W       = 4;
  localparam int MTX_NUM_IN  = 9;
  localparam int MTX_NUM_OUT = 11;

  localparam logic [SEL_W-1:0] SRC_SILENCE = 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUTE  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_APPLY = 2'd3
  } route_state_e;

  // A command is rejected for dest 0, dest beyond the last output, or src beyond the last input.
  function automatic logic route_cmd_bad(input logic [SEL_W-1:0] dest,
                                         input logic [SEL_W-1:0] src,
                                         input logic [SEL_W-1:0] dest_max,
                                         input logic [SEL_W-1:0] src_max);
    return (dest == 4'd0) || (dest > dest_max) || (src > src_max);
  endfunction

endpackage

// File: rtl/matrix_route_ctrl_if.sv
// Route command valid/ready channel between a host and the matrix route controller.
interface matrix_route_ctrl_if;
  import matrix_route_ctrl_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [SEL_W-1:0] cmd_dest;
  logic [SEL_W-1:0] cmd_src;

  modport master (output cmd_valid, output cmd_dest, output cmd_src, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_dest, input cmd_src, output cmd_ready);

endinterface

// File: rtl/matrix_route_ctrl.sv
// Click-free route sequencer for the 9x11 audio matrix: mutes a destination for
// MUTE_SAMPLES sample periods before connecting its new source, updating only on sample_tick.
module matrix_route_ctrl
  import matrix_route_ctrl_pkg::*;
#(
  parameter int NUM_OUT      = MTX_NUM_OUT,
  parameter int NUM_IN       = MTX_NUM_IN,
  parameter int MUTE_SAMPLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_tick,
  input  logic                     clear_all,
  matrix_route_ctrl_if.slave       cmd,
  output logic [SEL_W*NUM_OUT-1:0] sel_bus,
  output logic                     busy,
  output logic                     cmd_err,
  input  logic [SEL_W-1:0]         rd_dest,
  output logic [SEL_W-1:0]         rd_src
);

  localparam int               CNT_W    = $clog2(MUTE_SAMPLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUTE_SAMPLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [SEL_W-1:0] DEST_MAX = SEL_W'(NUM_OUT);
  localparam logic [SEL_W-1:0] SRC_MAX  = SEL_W'(NUM_IN);

  route_state_e     state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [SEL_W-1:0] dest_r, dest_s;
  logic [SEL_W-1:0] src_r, src_s;
  logic [SEL_W-1:0] sel_r [NUM_OUT];
  logic [SEL_W-1:0] sel_s [NUM_OUT];
  logic             clr_pend_r, clr_pend_s;
  logic             ready_r, ready_s;
  logic             busy_r, busy_s;
  logic             err_r, err_s;
  logic [SEL_W-1:0] rd_src_r, rd_src_s;
  logic             xfer_s;
  logic [SEL_W-1:0] cmd_idx_s;
  logic [SEL_W-1:0] rd_idx_s;

  // Next-state, select updates, validation and readback selection.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    dest_s     = dest_r;
    src_s      = src_r;
    sel_s      = sel_r;
    clr_pend_s = clr_pend_r;
    err_s      = 1'b0;
    xfer_s     = cmd.cmd_valid & ready_r;
    cmd_idx_s  = cmd.cmd_dest - 4'd1;
    rd_idx_s   = rd_dest - 4'd1;

    if (clr_pend_r && sample_tick) begin
      // A pending clear overrides whatever sequence is in flight.
      for (int i = 0; i < NUM_OUT; i++) begin
        sel_s[i] = SRC_SILENCE;
      end
      state_s    = ST_IDLE;
      cnt_s      = {CNT_W{1'b0}};
      clr_pend_s = 1'b0;
    end else begin
      if (clear_all) begin
        clr_pend_s = 1'b1;
      end else begin
        clr_pend_s = clr_pend_r;
      end
      case (state_r)
        ST_IDLE: begin
          if (xfer_s && !clear_all) begin
            if (route_cmd_bad(cmd.cmd_dest, cmd.cmd_src, DEST_MAX, SRC_MAX)) begin
              err_s = 1'b1;
            end else if (cmd.cmd_src == sel_r[cmd_idx_s]) begin
              state_s = ST_IDLE;
            end else begin
              dest_s  = cmd_idx_s;
              src_s   = cmd.cmd_src;
              state_s = ST_MUTE;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_MUTE: begin
          if (sample_tick) begin
            sel_s[dest_r] = SRC_SILENCE;
            if (src_r == SRC_SILENCE) begin
              state_s = ST_IDLE;
            end else if (CNT_LOAD == {CNT_W{1'b0}}) begin
              cnt_s   = CNT_LOAD;
              state_s = ST_APPLY;
            end else begin
              cnt_s   = CNT_LOAD;
              state_s = ST_HOLD;
            end
          end else begin
            state_s = ST_MUTE;
          end
        end
        ST_HOLD: begin
          if (sample_tick) begin
            cnt_s = cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) begin
              state_s = ST_APPLY;
            end else begin
              state_s = ST_HOLD;
            end
          end else begin
            state_s = ST_HOLD;
          end
        end
        ST_APPLY: begin
          if (sample_tick) begin
            sel_s[dest_r] = src_r;
            state_s       = ST_IDLE;
          end else begin
            state_s = ST_APPLY;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end

    ready_s = (state_s == ST_IDLE) && !clr_pend_s;
    busy_s  = (state_s != ST_IDLE) || clr_pend_s;

    if ((rd_dest != 4'd0) && (rd_dest <= DEST_MAX)) begin
      rd_src_s = sel_r[rd_idx_s];
    end else begin
      rd_src_s = SRC_SILENCE;
    end
  end

  // State, select array and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      dest_r     <= 4'd0;
      src_r      <= SRC_SILENCE;
      clr_pend_r <= 1'b0;
      ready_r    <= 1'b0;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
      rd_src_r   <= SRC_SILENCE;
      for (int i = 0; i < NUM_OUT; i++) begin
        sel_r[i] <= SRC_SILENCE;
      end
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      dest_r     <= dest_s;
      src_r      <= src_s;
      clr_pend_r <= clr_pend_s;
      ready_r    <= ready_s;
      busy_r     <= busy_s;
      err_r      <= err_s;
      rd_src_r   <= rd_src_s;
      sel_r      <= sel_s;
    end
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_pack
    assign sel_bus[g*SEL_W +: SEL_W] = sel_r[g];
  end

  assign cmd.cmd_ready = ready_r;
  assign busy          = busy_r;
  assign cmd_err       = err_r;
  assign rd_src        = rd_src_r;

endmodule

// File: tb/tb_matrix_route_ctrl.sv
// Directed bench for matrix_route_ctrl: sample_tick every 8 clocks, expected selects kept in a
// hand-updated table.
module tb_matrix_route_ctrl;
  import matrix_route_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_tick;
  logic        clear_all;
  logic [43:0] sel_bus;
  logic        busy;
  logic        cmd_err;
  logic [3:0]  rd_dest;
  logic [3:0]  rd_src;

  int n_chk  = 0;
  int n_fail = 0;

  logic [3:0] exp_sel [1:11];

  matrix_route_ctrl_if cmd_if ();

  matrix_route_ctrl #(.NUM_OUT(11), .NUM_IN(9), .MUTE_SAMPLES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_tick (sample_tick),
    .clear_all   (clear_all),
    .cmd         (cmd_if),
    .sel_bus     (sel_bus),
    .busy        (busy),
    .cmd_err     (cmd_err),
    .rd_dest     (rd_dest),
    .rd_src      (rd_src)
  );

  always #5 clk = ~clk;

  function automatic logic [43:0] exp_bus();
    logic [43:0] v;
    v = 44'd0;
    for (int i = 1; i <= 11; i++) v[4*i-4 +: 4] = exp_sel[i];
    return v;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Seven idle clocks then a one-cycle tick; returns on the negedge after the tick edge.
  task automatic do_tick();
    cyc(7);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  // Presents a command, waits (bounded) for ready, returns on the negedge after the transfer edge.
  task automatic send_cmd(input logic [3:0] d, input logic [3:0] s);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_dest  = d;
    cmd_if.cmd_src   = s;
    for (int k = 0; k < 64 && cmd_if.cmd_ready !== 1'b1; k++) @(negedge clk);
    n_chk++;
    if (cmd_if.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_ready_timeout: got %b expected 1", cmd_if.cmd_ready);
    end
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_chk++; if (sel_bus !== 44'd0) begin n_fail++; $display("FAIL rst_sel: got %h expected 0", sel_bus); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_chk++; if (cmd_if.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b expected 0", cmd_if.cmd_ready); end
    n_chk++; if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b expected 0", cmd_err); end
    n_chk++; if (rd_src !== 4'd0) begin n_fail++; $display("FAIL rst_rd: got %h expected 0", rd_src); end
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (cmd_if.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b expected 1", cmd_if.cmd_ready); end
  endtask

  task automatic test_route();
    send_cmd(4'd3, 4'd5);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL route_busy: got %b expected 1", busy); end
    do_tick();
    n_chk++; if (sel_bus !== exp_bus()) begin n_fail++; $display("FAIL route_tick1: got %h expected %h", sel_bus, exp_bus()); end
    do_tick();
    n_chk++; if (sel_bus !== exp_bus()) begin n_fail++; $display("FAIL route_tick2: got %h expected %h", sel_bus, exp_bus()); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL route_busy2: got %b expected 1", busy); end
    do_tick();
    exp_sel[3] = 4'd5;
    n_chk++; if (sel_bus !== exp_bus()) begin n_fail++; $display("FAIL route_tick3: got %h expected %h", sel_bus, exp_bus()); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL route_busy_fall: got %b expected 0", busy); end
  endtask

  task automatic test_invalid();
    logic [3:0] bd [3];
    logic [3:0] bs [3];
    bd = '{4'd0, 4'd12, 4'd3};
    bs = '{4'd1, 4'd1, 4'd10};
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (cmd_if.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL inv_ready[%0d]: got %b expected 1", i, cmd_if.cmd_ready); end
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_dest  = bd[i];
      cmd_if.cmd_src   = bs[i];
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
      n_chk++; if (cmd_err !== 1'b1) begin n_fail++; $display("FAIL inv_err[%0d]: got %b expected 1", i, cmd_err); end
      @(negedge clk);
      n_chk++; if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL inv_err_pulse[%0d]: got %b expected 0", i, cmd_err); end
      n_chk++; if (sel_bus !== exp_bus()) begin n_fail++; $display("FAIL inv_sel[%0d]: got %h expected %h", i, sel_bus, exp_bus()); end
    end
  endtask

  task automatic test_noop_and_hold();
    send_cmd(4'd7, 4'd2);
    repeat (3) do_tick();
    exp_sel[7] = 4'd2;
    n_chk++; if (sel_bus !== exp_bus()) begin n_fail++; $display("FAIL noop_first: got %h expected %h", sel_bus, exp_bus()); end
    send_cmd(4'd7, 4'd2);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL noop_busy: got %b expected 0", busy); end
    n_chk++; if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL noop_err: got %b expected 0", cmd_err); end
    send_cmd(4'd3, 4'd1);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_dest  = 4'd4;
    cmd_if.cmd_src   = 4'd8;
    n_chk++; if (cmd_if.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready: got %b expected 0", cmd_if.cmd_ready); end
    do_tick();
    exp_sel[3] = 4'd0;
    n_chk++; if (sel_bus !== exp_bus()) begin n_fail++; $display("FAIL hold_mute: got %h expected %h", sel_bus, exp_bus()); end
    do_tick();
    do_tick();
    exp_sel[3] = 4'd1;
    n_chk++; if (sel_bus !== exp_bus()) begin n_fail++; $display("FAIL hold_apply: got %h expected %h", sel_bus, exp_bus()); end
    n_chk++; if (cmd_if.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL hold_ready_idle: got %b expected 1", cmd_if.cmd_ready); end
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL hold_xfer_busy: got %b expected 1", busy); end
    repeat (3) do_tick();
    exp_sel[4] = 4'd8;
    n_chk++; if (sel_bus !== exp_bus()) begin n_fail++; $display("FAIL hold_second: got %h expected %h", sel_bus, exp_bus()); end
  endtask

  task automatic test_clear();
    send_cmd(4'd1, 4'd9);
    do_tick();
    cyc(2);
    clear_all = 1'b1;
    @(negedge clk);
    clear_all = 1'b0;
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL clr_busy: got %b expected 1", busy); end
    do_tick();
    for (int i = 1; i <= 11; i++) exp_sel[i] = 4'd0;
    n_chk++; if (sel_bus !== 44'd0) begin n_fail++; $display("FAIL clr_sel: got %h expected 0", sel_bus); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_idle: got %b expected 0", busy); end
    // Command presented together with clear_all is dropped silently.
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_dest  = 4'd2;
    cmd_if.cmd_src   = 4'd3;
    clear_all        = 1'b1;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    clear_all        = 1'b0;
    n_chk++; if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL clr_drop_err: got %b expected 0", cmd_err); end
    repeat (4) do_tick();
    n_chk++; if (sel_bus !== 44'd0) begin n_fail++; $display("FAIL clr_never_routed: got %h expected 0", sel_bus); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_drop_idle: got %b expected 0", busy); end
  endtask

  task automatic test_tick_on_transfer();
    rd_dest          = 4'd11;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_dest  = 4'd11;
    cmd_if.cmd_src   = 4'd1;
    sample_tick      = 1'b1;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    sample_tick      = 1'b0;
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL tt_busy: got %b expected 1", busy); end
    do_tick();
    do_tick();
    n_chk++; if (sel_bus !== exp_bus()) begin n_fail++; $display("FAIL tt_not_early: got %h expected %h", sel_bus, exp_bus()); end
    do_tick();
    exp_sel[11] = 4'd1;
    n_chk++; if (sel_bus !== exp_bus()) begin n_fail++; $display("FAIL tt_apply: got %h expected %h", sel_bus, exp_bus()); end
    @(negedge clk);
    n_chk++; if (rd_src !== 4'd1) begin n_fail++; $display("FAIL tt_readback: got %h expected 1", rd_src); end
    rd_dest = 4'd13;
    @(negedge clk);
    n_chk++; if (rd_src !== 4'd0) begin n_fail++; $display("FAIL tt_rd_oob: got %h expected 0", rd_src); end
    // Clear coinciding with a tick waits for the following tick.
    clear_all   = 1'b1;
    sample_tick = 1'b1;
    @(negedge clk);
    clear_all   = 1'b0;
    sample_tick = 1'b0;
    n_chk++; if (sel_bus !== exp_bus()) begin n_fail++; $display("FAIL tt_clr_defer: got %h expected %h", sel_bus, exp_bus()); end
    do_tick();
    exp_sel[11] = 4'd0;
    n_chk++; if (sel_bus !== 44'd0) begin n_fail++; $display("FAIL tt_clr_apply: got %h expected 0", sel_bus); end
  endtask

  task automatic test_reset_mid_hold();
    send_cmd(4'd2, 4'd6);
    repeat (3) do_tick();
    exp_sel[2] = 4'd6;
    n_chk++; if (sel_bus !== exp_bus()) begin n_fail++; $display("FAIL rmh_setup: got %h expected %h", sel_bus, exp_bus()); end
    send_cmd(4'd5, 4'd3);
    do_tick();
    rst = 1'b1;
    #1;
    exp_sel[2] = 4'd0;
    n_chk++; if (sel_bus !== 44'd0) begin n_fail++; $display("FAIL rmh_sel: got %h expected 0", sel_bus); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmh_busy: got %b expected 0", busy); end
    n_chk++; if (cmd_if.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rmh_ready_in_rst: got %b expected 0", cmd_if.cmd_ready); end
    cyc(2);
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (cmd_if.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rmh_ready: got %b expected 1", cmd_if.cmd_ready); end
    repeat (3) do_tick();
    n_chk++; if (sel_bus !== 44'd0) begin n_fail++; $display("FAIL rmh_no_resume: got %h expected 0", sel_bus); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmh_busy_after: got %b expected 0", busy); end
  endtask

  initial begin
    rst              = 1'b1;
    sample_tick      = 1'b0;
    clear_all        = 1'b0;
    rd_dest          = 4'd0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_dest  = 4'd0;
    cmd_if.cmd_src   = 4'd0;
    for (int i = 1; i <= 11; i++) exp_sel[i] = 4'd0;
    cyc(3);
    test_reset();
    test_route();
    test_invalid();
    test_noop_and_hold();
    test_clear();
    test_tick_on_transfer();
    test_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
